// File: rtl/enduro_sync_fifo_cntl_if.sv
// Request/status bundle between a FIFO user (master) and enduro_sync_fifo_cntl (slave).
// DEPTH must match the controller instance; widths are derived from it.
interface enduro_sync_fifo_cntl_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned LVL_WIDTH  = $clog2(DEPTH + 1);

    logic                  inc_wr_pointer;
    logic                  inc_rd_pointer;
    logic                  flush;
    logic [LVL_WIDTH-1:0]  full_thresh;
    logic [LVL_WIDTH-1:0]  empty_thresh;
    logic                  err_clear;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  full_ff;
    logic                  empty_ff;
    logic                  almost_full_ff;
    logic                  almost_empty_ff;
    logic [LVL_WIDTH-1:0]  level_ff;
    logic [ADDR_WIDTH-1:0] wr_mem_addr;
    logic [ADDR_WIDTH-1:0] rd_mem_addr;
    logic                  overflow_ff;
    logic                  underflow_ff;

    modport master (
        output inc_wr_pointer, inc_rd_pointer, flush, full_thresh, empty_thresh, err_clear,
        input  wr_accept, rd_accept, full_ff, empty_ff, almost_full_ff, almost_empty_ff,
        input  level_ff, wr_mem_addr, rd_mem_addr, overflow_ff, underflow_ff
    );

    modport slave (
        input  inc_wr_pointer, inc_rd_pointer, flush, full_thresh, empty_thresh, err_clear,
        output wr_accept, rd_accept, full_ff, empty_ff, almost_full_ff, almost_empty_ff,
        output level_ff, wr_mem_addr, rd_mem_addr, overflow_ff, underflow_ff
    );
endinterface

// File: rtl/enduro_sync_fifo_cntl.sv
// Single-clock FIFO controller for any DEPTH: RAM pointers, fill level, threshold flags, flush.
// Define ENDURO_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module enduro_sync_fifo_cntl #(
    parameter int unsigned DEPTH = 16
) (
    input logic                    axis_clk,
    input logic                    axis_aresetn,
    enduro_sync_fifo_cntl_if.slave fifo
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned LVL_WIDTH  = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [LVL_WIDTH-1:0]  FULL_LVL  = LVL_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [LVL_WIDTH-1:0]  level, level_next;
    logic                  full, empty, almost_full, almost_empty;
    logic                  wr_acc, rd_acc;

    always_comb begin
        wr_acc      = fifo.inc_wr_pointer & ~full & ~fifo.flush;
        rd_acc      = fifo.inc_rd_pointer & ~empty & ~fifo.flush;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (fifo.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (wr_acc) wr_ptr_next = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_WIDTH'(1);
            if (rd_acc) rd_ptr_next = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_WIDTH'(1);
            // Accepts are gated by full/empty, so +1/-1 can never leave 0..DEPTH.
            unique case ({wr_acc, rd_acc})
                2'b10:   level_next = level + LVL_WIDTH'(1);
                2'b01:   level_next = level - LVL_WIDTH'(1);
                default: level_next = level;
            endcase
        end
    end

    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            level        <= level_next;
            full         <= (level_next == FULL_LVL);
            empty        <= (level_next == '0);
            almost_full  <= (level_next >= fifo.full_thresh);
            almost_empty <= (level_next < fifo.empty_thresh);
        end
    end

    assign fifo.wr_accept       = wr_acc;
    assign fifo.rd_accept       = rd_acc;
    assign fifo.full_ff         = full;
    assign fifo.empty_ff        = empty;
    assign fifo.almost_full_ff  = almost_full;
    assign fifo.almost_empty_ff = almost_empty;
    assign fifo.level_ff        = level;
    assign fifo.wr_mem_addr     = wr_ptr;
    assign fifo.rd_mem_addr     = rd_ptr;

`ifdef ENDURO_FIFO_ERR_EN
    logic overflow, underflow;

    // A new error event takes precedence over a clear in the same cycle.
    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fifo.inc_wr_pointer & full & ~fifo.flush) overflow <= 1'b1;
            else if (fifo.err_clear)                      overflow <= 1'b0;
            if (fifo.inc_rd_pointer & empty & ~fifo.flush) underflow <= 1'b1;
            else if (fifo.err_clear)                       underflow <= 1'b0;
        end
    end

    assign fifo.overflow_ff  = overflow;
    assign fifo.underflow_ff = underflow;
`else
    logic unused_err_clear;
    assign unused_err_clear  = fifo.err_clear;
    assign fifo.overflow_ff  = 1'b0;
    assign fifo.underflow_ff = 1'b0;
`endif
endmodule

// File: tb/tb_enduro_sync_fifo_cntl.sv
// Drives a DEPTH=5 and a DEPTH=16 controller with shared directed and random requests,
// comparing both against an occupancy-count reference model.
module tb_enduro_sync_fifo_cntl;
    localparam int unsigned NDUT = 2;
    localparam int unsigned D0 = 5;
    localparam int unsigned D1 = 16;
    localparam int unsigned L0 = $clog2(D0 + 1);
    localparam int unsigned L1 = $clog2(D1 + 1);
`ifdef ENDURO_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    int unsigned dep [NDUT] = '{D0, D1};

    logic axis_clk = 1'b0;
    logic axis_aresetn = 1'b0;
    logic push = 1'b0, pop = 1'b0, flush = 1'b0, err_clear = 1'b0;
    int unsigned fth [NDUT] = '{0, 0};
    int unsigned eth [NDUT] = '{0, 0};
    int checks = 0;
    int failures = 0;

    int unsigned m_level [NDUT], m_wp [NDUT], m_rp [NDUT];
    bit          m_af [NDUT], m_ae [NDUT], m_ovf [NDUT], m_unf [NDUT];

    logic [31:0] o_wa [NDUT], o_ra [NDUT], o_full [NDUT], o_empty [NDUT], o_af [NDUT];
    logic [31:0] o_ae [NDUT], o_level [NDUT], o_waddr [NDUT], o_raddr [NDUT];
    logic [31:0] o_ovf [NDUT], o_unf [NDUT];

    enduro_sync_fifo_cntl_if #(.DEPTH(D0)) bus0 ();
    enduro_sync_fifo_cntl_if #(.DEPTH(D1)) bus1 ();

    enduro_sync_fifo_cntl #(.DEPTH(D0)) dut0 (
        .axis_clk     (axis_clk),
        .axis_aresetn (axis_aresetn),
        .fifo         (bus0)
    );
    enduro_sync_fifo_cntl #(.DEPTH(D1)) dut1 (
        .axis_clk     (axis_clk),
        .axis_aresetn (axis_aresetn),
        .fifo         (bus1)
    );

    assign bus0.inc_wr_pointer = push;
    assign bus0.inc_rd_pointer = pop;
    assign bus0.flush          = flush;
    assign bus0.err_clear      = err_clear;
    assign bus0.full_thresh    = L0'(fth[0]);
    assign bus0.empty_thresh   = L0'(eth[0]);
    assign bus1.inc_wr_pointer = push;
    assign bus1.inc_rd_pointer = pop;
    assign bus1.flush          = flush;
    assign bus1.err_clear      = err_clear;
    assign bus1.full_thresh    = L1'(fth[1]);
    assign bus1.empty_thresh   = L1'(eth[1]);

    assign o_wa[0]    = 32'(bus0.wr_accept);
    assign o_ra[0]    = 32'(bus0.rd_accept);
    assign o_full[0]  = 32'(bus0.full_ff);
    assign o_empty[0] = 32'(bus0.empty_ff);
    assign o_af[0]    = 32'(bus0.almost_full_ff);
    assign o_ae[0]    = 32'(bus0.almost_empty_ff);
    assign o_level[0] = 32'(bus0.level_ff);
    assign o_waddr[0] = 32'(bus0.wr_mem_addr);
    assign o_raddr[0] = 32'(bus0.rd_mem_addr);
    assign o_ovf[0]   = 32'(bus0.overflow_ff);
    assign o_unf[0]   = 32'(bus0.underflow_ff);
    assign o_wa[1]    = 32'(bus1.wr_accept);
    assign o_ra[1]    = 32'(bus1.rd_accept);
    assign o_full[1]  = 32'(bus1.full_ff);
    assign o_empty[1] = 32'(bus1.empty_ff);
    assign o_af[1]    = 32'(bus1.almost_full_ff);
    assign o_ae[1]    = 32'(bus1.almost_empty_ff);
    assign o_level[1] = 32'(bus1.level_ff);
    assign o_waddr[1] = 32'(bus1.wr_mem_addr);
    assign o_raddr[1] = 32'(bus1.rd_mem_addr);
    assign o_ovf[1]   = 32'(bus1.overflow_ff);
    assign o_unf[1]   = 32'(bus1.underflow_ff);

    always #5 axis_clk = ~axis_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            m_level[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
            m_af[k] = 1'b0; m_ae[k] = 1'b1; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end
    endtask

    // Occupancy-count view: pointers advance modulo DEPTH, flags follow the new count.
    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            bit is_full, is_empty, wa, ra;
            is_full  = (m_level[k] == dep[k]);
            is_empty = (m_level[k] == 0);
            wa = push && !is_full && !flush;
            ra = pop && !is_empty && !flush;
            if (ERR_EN) begin
                if (push && is_full && !flush) m_ovf[k] = 1'b1;
                else if (err_clear)            m_ovf[k] = 1'b0;
                if (pop && is_empty && !flush) m_unf[k] = 1'b1;
                else if (err_clear)            m_unf[k] = 1'b0;
            end
            if (flush) begin
                m_level[k] = 0; m_wp[k] = 0; m_rp[k] = 0;
            end else begin
                m_level[k] = m_level[k] + int'(wa) - int'(ra);
                if (wa) m_wp[k] = (m_wp[k] + 1) % dep[k];
                if (ra) m_rp[k] = (m_rp[k] + 1) % dep[k];
            end
            m_af[k] = (m_level[k] >= fth[k]);
            m_ae[k] = (m_level[k] < eth[k]);
        end
    endtask

    task automatic check_state(input string w);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s d%0d level", w, dep[k]), o_level[k], m_level[k]);
            chk($sformatf("%s d%0d full", w, dep[k]), o_full[k], 32'(m_level[k] == dep[k]));
            chk($sformatf("%s d%0d empty", w, dep[k]), o_empty[k], 32'(m_level[k] == 0));
            chk($sformatf("%s d%0d almost_full", w, dep[k]), o_af[k], 32'(m_af[k]));
            chk($sformatf("%s d%0d almost_empty", w, dep[k]), o_ae[k], 32'(m_ae[k]));
            chk($sformatf("%s d%0d wr_addr", w, dep[k]), o_waddr[k], m_wp[k]);
            chk($sformatf("%s d%0d rd_addr", w, dep[k]), o_raddr[k], m_rp[k]);
            chk($sformatf("%s d%0d overflow", w, dep[k]), o_ovf[k], 32'(m_ovf[k]));
            chk($sformatf("%s d%0d underflow", w, dep[k]), o_unf[k], 32'(m_unf[k]));
        end
    endtask

    task automatic cycle(input bit p, input bit q, input bit f, input bit c);
        @(negedge axis_clk);
        push = p; pop = q; flush = f; err_clear = c;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d wr_accept", dep[k]), o_wa[k],
                32'(push && m_level[k] != dep[k] && !flush));
            chk($sformatf("d%0d rd_accept", dep[k]), o_ra[k],
                32'(pop && m_level[k] != 0 && !flush));
        end
        @(posedge axis_clk);
        model_edge();
        #1;
        check_state("edge");
    endtask

    task automatic do_reset();
        @(negedge axis_clk);
        axis_aresetn = 1'b0;
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clear = 1'b0;
        #1;
        model_reset();
        check_state("reset");
        @(negedge axis_clk);
        axis_aresetn = 1'b1;
    endtask

    initial begin
        int unsigned push_pct, pop_pct;
        do_reset();
        fth = '{3, 12};
        eth = '{2, 4};

        repeat (5) cycle(1, 0, 0, 0);
        chk("d5 level after 5 pushes", o_level[0], 5);
        chk("d5 full after 5 pushes", o_full[0], 1);
        chk("d5 wr_addr wrapped", o_waddr[0], 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        chk("d5 full push+pop level", o_level[0], 4);
        chk("d5 full push+pop full", o_full[0], 0);
        repeat (6) cycle(1, 0, 0, 0);
        chk("d16 level 12", o_level[1], 12);
        chk("d16 almost_full at 12", o_af[1], 1);
        repeat (9) cycle(0, 1, 0, 0);
        chk("d16 level 3", o_level[1], 3);
        chk("d16 almost_empty at 3", o_ae[1], 1);
        repeat (4) cycle(1, 0, 0, 0);
        chk("d16 level 7", o_level[1], 7);
        cycle(1, 0, 1, 0);
        chk("flush d16 level", o_level[1], 0);
        chk("flush d16 wr_addr", o_waddr[1], 0);
        chk("flush d16 empty", o_empty[1], 1);
        cycle(1, 1, 0, 0);
        chk("empty push+pop level", o_level[0], 1);
        chk("empty push+pop empty", o_empty[0], 0);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("underflow sticky", o_unf[0], 32'(ERR_EN));
        cycle(0, 0, 0, 0);
        chk("underflow held", o_unf[0], 32'(ERR_EN));
        cycle(0, 0, 0, 1);
        chk("underflow cleared", o_unf[0], 0);
        fth = '{0, 0};
        eth = '{0, 0};
        do_reset();
        cycle(0, 0, 0, 0);
        chk("fth0 almost_full", o_af[0], 1);
        chk("eth0 almost_empty", o_ae[0], 0);

        push_pct = 50; pop_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 48 == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin push_pct = 85; pop_pct = 25; end
                    1:       begin push_pct = 25; pop_pct = 85; end
                    default: begin push_pct = 60; pop_pct = 60; end
                endcase
            end
            if (n % 20 == 0) begin
                for (int k = 0; k < NDUT; k++) begin
                    fth[k] = $urandom_range(0, dep[k] + 1);
                    eth[k] = $urandom_range(0, dep[k] + 1);
                end
            end
            if (n == 777) begin
                do_reset();
                chk("mid-run reset level", o_level[1], 0);
            end
            cycle($urandom_range(0, 99) < push_pct, $urandom_range(0, 99) < pop_pct,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
